if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and optional perf counters.
// Define IF_PERF_CNT_EN to build the perf counters; without it the perf_* outputs are tied to 0.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_if_id,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc_reg;
  logic [31:0] if_id_pc_plus4_reg;
  logic [31:0] if_id_instr_reg;
  logic        if_id_valid_reg;
  logic        if_id_load;

  // Targets are word aligned; the two low bits are dropped deliberately.
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];

  assign pc_plus4   = pc_reg + 32'd4;
  assign if_id_load = !flush_if_id && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg <= {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_reg <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_pc_reg       <= 32'd0;
      if_id_pc_plus4_reg <= 32'd0;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_valid_reg    <= 1'b0;
    end else if (flush_if_id) begin
      if_id_pc_reg       <= 32'd0;
      if_id_pc_plus4_reg <= 32'd0;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_valid_reg    <= 1'b0;
    end else if (!stall) begin
      if_id_pc_reg       <= pc_reg;
      if_id_pc_plus4_reg <= pc_plus4;
      if_id_instr_reg    <= imem_rdata;
      if_id_valid_reg    <= 1'b1;
    end
  end

  assign pc             = pc_reg;
  assign imem_addr      = pc_reg;
  assign if_id_pc       = if_id_pc_reg;
  assign if_id_pc_plus4 = if_id_pc_plus4_reg;
  assign if_id_instr    = if_id_instr_reg;
  assign if_id_valid    = if_id_valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // A stall that coincides with a flush counts as a flush only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (if_id_load)             fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (stall && !flush_if_id)  stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush_if_id)            flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`else
  logic unused_load;
  assign unused_load    = if_id_load;
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch sequence, stall, redirect/flush priority, PC wrap and async reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hC0DE_0000;
`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush_if_id;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] imem_addr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory returns an address-derived word so each fetch is identifiable.
  assign imem_rdata = imem_addr ^ KEY;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_if_id(flush_if_id),
    .redirect(redirect), .redirect_target(redirect_target), .imem_rdata(imem_rdata),
    .pc(pc), .imem_addr(imem_addr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h if_id_pc=%h p4=%h instr=%h v=%0d cnt f/s/fl=%0d/%0d/%0d",
             $time, pc, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid,
             perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush_if_id = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    #20;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, NOP); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc_plus4); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc !== 32'(4*i+4)) begin failures++; $display("FAIL fetch_pc[%0d] got=%h exp=%h", i, pc, 32'(4*i+4)); end
      checks++; if (imem_addr !== 32'(4*i+4)) begin failures++; $display("FAIL fetch_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4*i+4)); end
      checks++; if (if_id_pc !== 32'(4*i) || if_id_pc_plus4 !== 32'(4*i+4)) begin failures++; $display("FAIL fetch_ifid_pc[%0d] got=%h/%h exp=%h/%h", i, if_id_pc, if_id_pc_plus4, 32'(4*i), 32'(4*i+4)); end
      checks++; if (if_id_instr !== (32'(4*i) ^ KEY) || if_id_valid !== 1'b1) begin failures++; $display("FAIL fetch_instr[%0d] got=%h v=%b exp=%h v=1", i, if_id_instr, if_id_valid, 32'(4*i) ^ KEY); end
    end
    checks++; if (perf_fetch_cnt !== pexp(4)) begin failures++; $display("FAIL fetch_cnt got=%0d exp=%0d", perf_fetch_cnt, pexp(4)); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h10); end
      checks++; if (if_id_pc !== 32'h0C || if_id_instr !== (32'h0C ^ KEY) || if_id_valid !== 1'b1) begin failures++; $display("FAIL stall_ifid[%0d] got=%h/%h/%b exp=%h/%h/1", i, if_id_pc, if_id_instr, if_id_valid, 32'h0C, 32'h0C ^ KEY); end
    end
    checks++; if (perf_stall_cnt !== pexp(2) || perf_fetch_cnt !== pexp(4)) begin failures++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", perf_stall_cnt, perf_fetch_cnt, pexp(2), pexp(4)); end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h14 || if_id_pc !== 32'h10) begin failures++; $display("FAIL stall_resume got=%h/%h exp=%h/%h", pc, if_id_pc, 32'h14, 32'h10); end
  endtask

  task automatic test_redirect_flush();
    redirect = 1'b1; redirect_target = 32'h50; flush_if_id = 1'b1;
    step();
    checks++; if (pc !== 32'h50) begin failures++; $display("FAIL redir_pc got=%h exp=%h", pc, 32'h50); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin failures++; $display("FAIL flush_ifid got=%b/%h exp=0/%h", if_id_valid, if_id_instr, NOP); end
    checks++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL flush_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc_plus4); end
    checks++; if (perf_flush_cnt !== pexp(1) || perf_fetch_cnt !== pexp(5)) begin failures++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", perf_flush_cnt, perf_fetch_cnt, pexp(1), pexp(5)); end
    redirect = 1'b0; flush_if_id = 1'b0;
    step();
    checks++; if (pc !== 32'h54 || if_id_pc !== 32'h50 || if_id_pc_plus4 !== 32'h54) begin failures++; $display("FAIL after_redir got=%h/%h/%h exp=54/50/54", pc, if_id_pc, if_id_pc_plus4); end
    checks++; if (if_id_instr !== (32'h50 ^ KEY) || if_id_valid !== 1'b1) begin failures++; $display("FAIL after_redir_instr got=%h/%b exp=%h/1", if_id_instr, if_id_valid, 32'h50 ^ KEY); end
  endtask

  task automatic test_priority();
    redirect = 1'b1; stall = 1'b1; redirect_target = 32'h42;
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redir_stall_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (if_id_pc !== 32'h50 || if_id_instr !== (32'h50 ^ KEY)) begin failures++; $display("FAIL redir_stall_hold got=%h/%h exp=50/%h", if_id_pc, if_id_instr, 32'h50 ^ KEY); end
    redirect = 1'b0; flush_if_id = 1'b1;
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL flush_stall_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin failures++; $display("FAIL flush_stall_ifid got=%b/%h/%h exp=0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP); end
    checks++; if (perf_stall_cnt !== pexp(3) || perf_flush_cnt !== pexp(2) || perf_fetch_cnt !== pexp(6)) begin failures++; $display("FAIL prio_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_stall_cnt, perf_flush_cnt, perf_fetch_cnt, pexp(3), pexp(2), pexp(6)); end
    stall = 1'b0; flush_if_id = 1'b0;
    step();
    checks++; if (pc !== 32'h44 || if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin failures++; $display("FAIL prio_resume got=%h/%h/%b exp=44/40/1", pc, if_id_pc, if_id_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got=%h exp=FFFFFFFC", pc); end
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_ifid got=%h/%h exp=FFFFFFFC/0", if_id_pc, if_id_pc_plus4); end
    checks++; if (perf_fetch_cnt !== pexp(9)) begin failures++; $display("FAIL wrap_cnt got=%0d exp=%0d", perf_fetch_cnt, pexp(9)); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) step();
    checks++; if (pc !== 32'h30) begin failures++; $display("FAIL mid_pre_pc got=%h exp=30", pc); end
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin failures++; $display("FAIL mid_async got=%h/%b/%h exp=0/0/%h", pc, if_id_valid, if_id_instr, NOP); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d/%0d exp=0/0/0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mid_hold got=%h exp=0", pc); end
    stall = 1'b0; redirect = 1'b0;
    #2;
    reset = 1'b1;
    step();
    checks++; if (pc !== 32'h4 || if_id_pc !== 32'h0 || if_id_instr !== KEY || if_id_valid !== 1'b1) begin failures++; $display("FAIL mid_restart got=%h/%h/%h/%b exp=4/0/%h/1", pc, if_id_pc, if_id_instr, if_id_valid, KEY); end
    checks++; if (perf_fetch_cnt !== pexp(1)) begin failures++; $display("FAIL mid_restart_cnt got=%0d exp=%0d", perf_fetch_cnt, pexp(1)); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_flush();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
